// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the iterative MULT/DIV sequencer.
// Optional high-word output is controlled by MULTDIV_HI_LO_EN (see multdiv_sequencer).
package multdiv_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Operation selector for one datapath iteration
    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    // Iteration counter width (holds 0..WIDTH for WIDTH=32, saturates at all-ones)
    localparam int ITER_CNT_W = 6;

    // Signed-divide overflow operands: INT_MIN / -1
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/multdiv_iter_step.sv
// multdiv_iter_step: one combinational radix-2 iteration on unsigned magnitudes.
//   OP_MULT: shift-add. {acc, shift} is the growing 2*WIDTH product, the multiplier
//            sits in shift and is consumed LSB first; i_mag is the multiplicand.
//   OP_DIV : restoring divide. acc is the partial remainder, shift holds the
//            dividend bits (MSB first) and collects quotient bits at the LSB;
//            i_mag is the divisor.
module multdiv_iter_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shift,
    input  logic [WIDTH-1:0] i_mag,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shift
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;

    // Compute the next accumulator / shift register for the selected operation
    always_comb begin
        // Multiply: add multiplicand (with carry out) when the current multiplier bit is set
        w_sum   = {1'b0, i_acc} + {1'b0, i_mag};
        // Divide: bring the next dividend bit into the partial remainder
        w_trial = {i_acc, i_shift[WIDTH-1]};
        // The difference is only kept when trial >= divisor, so it always fits WIDTH bits
        w_diff  = w_trial[WIDTH-1:0] - i_mag;

        o_acc   = i_acc;
        o_shift = i_shift;

        if (i_op == OP_MULT) begin
            if (i_shift[0]) begin
                o_acc   = w_sum[WIDTH:1];
                o_shift = {w_sum[0], i_shift[WIDTH-1:1]};
            end else begin
                o_acc   = {1'b0, i_acc[WIDTH-1:1]};
                o_shift = {i_acc[0], i_shift[WIDTH-1:1]};
            end
        end else begin
            if (w_trial >= {1'b0, i_mag}) begin
                o_acc   = w_diff;
                o_shift = {i_shift[WIDTH-2:0], 1'b1};
            end else begin
                o_acc   = w_trial[WIDTH-1:0];
                o_shift = {i_shift[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: multi-cycle signed MULT/DIV controller for the MIPS pipeline.
// Start pulses are taken in IDLE or DONE; WIDTH iterations run one per clock on
// operand magnitudes, then DONE presents result, exception and a one-cycle ready.
// Divide-by-zero short-circuits to DONE after one cycle.
// Build option: define MULTDIV_HI_LO_EN to add data_hi (product high word or
// signed remainder), updated together with data_result.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef MULTDIV_HI_LO_EN
    output logic [WIDTH-1:0] data_hi,
`endif
    output logic             busy
);

    localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(WIDTH - 1);

    // Absolute value as an unsigned magnitude; INT_MIN maps to 2^(WIDTH-1)
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    state_e                r_state;
    logic [ITER_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]      r_acc;
    logic [WIDTH-1:0]      r_shift;
    logic [WIDTH-1:0]      r_mag;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic                  r_dbz;
    logic                  r_ovf;
    logic [WIDTH-1:0]      r_result;
    logic                  r_exc;
    logic                  r_rdy;
    logic                  r_busy;
`ifdef MULTDIV_HI_LO_EN
    logic [WIDTH-1:0]      r_hi;
    logic [WIDTH-1:0]      w_hi;
`endif

    logic                  w_accept;
    logic                  w_go_mult;
    logic                  w_go_div;
    op_e                   w_op;
    logic [WIDTH-1:0]      w_acc_nxt;
    logic [WIDTH-1:0]      w_shift_nxt;
    logic                  w_neg;
    logic [2*WIDTH-1:0]    w_prod_mag;
    logic [2*WIDTH-1:0]    w_prod;
    logic [WIDTH-1:0]      w_quo;
    logic [WIDTH-1:0]      w_res;
    logic                  w_exc;

    // Start decode: only idle or just-finished accepts; multiply wins a tie
    always_comb begin
        w_accept  = (r_state == IDLE) || (r_state == DONE);
        w_go_mult = w_accept && ctrl_mult;
        w_go_div  = w_accept && ctrl_div && !ctrl_mult;
        w_op      = (r_state == DIV) ? OP_DIV : OP_MULT;
    end

    multdiv_iter_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .i_op    (w_op),
        .i_acc   (r_acc),
        .i_shift (r_shift),
        .i_mag   (r_mag),
        .o_acc   (w_acc_nxt),
        .o_shift (w_shift_nxt)
    );

    // Sign fix-up and exception detection on the final iteration's outputs
    always_comb begin
        w_neg      = r_sign_a ^ r_sign_b;
        w_prod_mag = {w_acc_nxt, w_shift_nxt};
        w_prod     = w_neg ? (~w_prod_mag + 1'b1) : w_prod_mag;
        w_quo      = w_neg ? (~w_shift_nxt + 1'b1) : w_shift_nxt;
        w_res      = w_quo;
        // INT_MIN / -1 naturally yields INT_MIN here; only the flag needs forcing
        w_exc      = r_ovf;
        if (r_state == MULT) begin
            w_res = w_prod[WIDTH-1:0];
            // Representable only if the upper WIDTH+1 bits are a pure sign extension
            w_exc = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
        end
`ifdef MULTDIV_HI_LO_EN
        // Remainder carries the dividend's sign
        w_hi = r_sign_a ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
        if (r_state == MULT) begin
            w_hi = w_prod[2*WIDTH-1:WIDTH];
        end
`endif
    end

    // FSM, iteration counter, datapath registers and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_shift  <= '0;
            r_mag    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
`ifdef MULTDIV_HI_LO_EN
            r_hi     <= '0;
`endif
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (w_go_mult || w_go_div) begin
                        r_state  <= w_go_mult ? MULT : DIV;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_sign_a <= data_operandA[WIDTH-1];
                        r_sign_b <= data_operandB[WIDTH-1];
                        // Multiply consumes B bit by bit; divide shifts A out
                        r_shift  <= w_go_mult ? magnitude(data_operandB) : magnitude(data_operandA);
                        r_mag    <= w_go_mult ? magnitude(data_operandA) : magnitude(data_operandB);
                        r_dbz    <= w_go_div && (data_operandB == '0);
                        r_ovf    <= w_go_div && (data_operandA == WIDTH'(INT_MIN))
                                             && (data_operandB == WIDTH'(NEG_ONE));
                    end
                end
                MULT, DIV: begin
                    if ((r_state == DIV) && r_dbz) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_rdy    <= 1'b1;
                        r_result <= '0;
                        r_exc    <= 1'b1;
`ifdef MULTDIV_HI_LO_EN
                        r_hi     <= '0;
`endif
                    end else begin
                        r_acc   <= w_acc_nxt;
                        r_shift <= w_shift_nxt;
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (r_cnt == LAST_ITER) begin
                            r_state  <= DONE;
                            r_busy   <= 1'b0;
                            r_rdy    <= 1'b1;
                            r_result <= w_res;
                            r_exc    <= w_exc;
`ifdef MULTDIV_HI_LO_EN
                            r_hi     <= w_hi;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;
`ifdef MULTDIV_HI_LO_EN
    assign data_hi        = r_hi;
`endif

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: table-driven vectors plus hand-written
// multi-cycle sequences; expected results go into a scoreboard queue at issue time
// and are popped when the DUT raises data_resultRDY.
module tb_multdiv_sequencer;

    logic        clock;
    logic        reset;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
`ifdef MULTDIV_HI_LO_EN
    logic [31:0] data_hi;
`endif

    multdiv_sequencer #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef MULTDIV_HI_LO_EN
        .data_hi        (data_hi),
`endif
        .busy           (busy)
    );

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [31:0] hi;
        int          lat;
        int          start;
    } exp_t;

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   rdy_cnt;
    bit   prev_rdy;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Result monitor: pops the scoreboard on every ready pulse
    always @(negedge clock) begin
        exp_t e;
        if (prev_rdy) chk("rdy_one_cycle", {31'b0, data_resultRDY}, 32'd0);
        if (data_resultRDY === 1'b1) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_rdy", {31'b0, data_resultRDY}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", data_result, e.res);
                chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
                chk("latency", cyc - e.start, e.lat);
                chk("busy_at_done", {31'b0, busy}, 32'd0);
`ifdef MULTDIV_HI_LO_EN
                chk("hi", data_hi, e.hi);
`endif
            end
        end
        prev_rdy = (data_resultRDY === 1'b1);
    end

    task automatic issue(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] er, input logic ee,
                         input logic [31:0] eh, input int lat);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_mult     = !is_div;
        ctrl_div      = is_div;
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        if (push) begin
            e.res   = er;
            e.exc   = ee;
            e.hi    = eh;
            e.lat   = lat;
            e.start = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clock);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: timeout with %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        n_cmp = 0; n_fail = 0; cyc = 0; rdy_cnt = 0; prev_rdy = 1'b0;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        data_operandA = '0; data_operandB = '0;

        //            div   A             B             result        exc   hi            lat
        vecs[0]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 32};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32};
        vecs[2]  = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1};
        vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h0000_0000, 32};
        vecs[4]  = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1, 32'h0000_0000, 32};
        vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 32};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h0000_0000, 32};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_001E, 1'b0, 32'h0000_0000, 32};
        vecs[8]  = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 32'h0000_0002, 32};
        vecs[9]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'h0000_0001, 32};
        vecs[10] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0, 32'hFFFF_FFFE, 32};
        vecs[11] = '{1'b1, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1'b0, 32'h0000_0000, 32};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 32};
        vecs[13] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32};
        vecs[14] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 32'h0000_0000, 32};

        // Reset state
        reset = 1'b0;
        #2;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exception", {31'b0, data_exception}, 32'd0);
        chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Basic multiply 7 x -3 with busy tracking across all iterations
        issue(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, 1'b0, 32'hFFFF_FFFF, 32);
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            chk("busy_in_flight", {31'b0, busy}, 32'd1);
        end
        drain("basic_mult");

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].is_div, vecs[i].a, vecs[i].b, 1'b1,
                  vecs[i].res, vecs[i].exc, vecs[i].hi, vecs[i].lat);
            drain("vector");
        end

        // Start while busy: the divide pulse at edge 10 must be ignored
        r0 = rdy_cnt;
        issue(1'b0, 32'd3, 32'd4, 1'b1, 32'd12, 1'b0, 32'd0, 32);
        repeat (9) @(posedge clock);
        #1;
        data_operandA = 32'd100;
        data_operandB = 32'd5;
        ctrl_div      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        repeat (40) @(negedge clock);
        #1;
        chk("start_busy_pulses", rdy_cnt - r0, 32'd1);
        drain("start_busy");

        // Asynchronous reset in the middle of a multiply
        issue(1'b0, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 32'd0, 0);
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_busy", {31'b0, busy}, 32'd0);
        chk("midreset_result", data_result, 32'd0);
        chk("midreset_rdy", {31'b0, data_resultRDY}, 32'd0);
        chk("midreset_exception", {31'b0, data_exception}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("postreset_busy", {31'b0, busy}, 32'd0);
        issue(1'b0, 32'd2, 32'd2, 1'b1, 32'd4, 1'b0, 32'd0, 32);
        drain("after_reset");

        // Back-to-back: new multiply issued while predecessor sits in DONE
        issue(1'b0, 32'd5, 32'd5, 1'b1, 32'd25, 1'b0, 32'd0, 32);
        repeat (32) @(posedge clock);
        #1;
        issue(1'b0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0, 32'd0, 32);
        @(negedge clock);
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_prev_result", data_result, 32'd25);
        drain("back_to_back");

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
